// File: rtl/seq_multiplier_pkg.sv
// ----------------------------------------------------------------------------
// seq_multiplier_pkg
//   Shared types and constants for the sequential 32x32 multiplier.
//   - mul_op_e    : RISC-V M-extension multiply flavours (encoded as i_op)
//   - mul_state_e : controller states IDLE -> MUL -> FIX1 -> FIX2 -> DONE
//   - MUL_ITER    : number of shift-add iterations (one per multiplier bit)
//   - helpers telling which operand is treated as two's complement per op
// ----------------------------------------------------------------------------
package seq_multiplier_pkg;

    localparam int unsigned MUL_ITER = 32;
    localparam int unsigned ITER_W   = $clog2(MUL_ITER);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_FIX1,
        ST_FIX2,
        ST_DONE
    } mul_state_e;

    // Multiplicand is signed for MULH and MULHSU.
    function automatic logic rs1_is_signed(input mul_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    // Multiplier is signed for MULH only.
    function automatic logic rs2_is_signed(input mul_op_e op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/seq_multiplier_adder.sv
// ----------------------------------------------------------------------------
// adder
//   Ripple-carry adder shared by every arithmetic step of the multiplier.
//   Ports:
//     op_a, op_b : WIDTH-bit addends
//     cin        : carry in (set to 1 with an inverted op_b to subtract)
//     cout       : carry out of the top bit
//     sum        : WIDTH-bit sum
// ----------------------------------------------------------------------------
module adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             cout,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] w_carry;

    always_comb begin
        w_carry    = '0;
        sum        = '0;
        w_carry[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i]       = op_a[i] ^ op_b[i] ^ w_carry[i];
            w_carry[i+1] = (op_a[i] & op_b[i]) | (w_carry[i] & (op_a[i] ^ op_b[i]));
        end
    end

    assign cout = w_carry[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier
//   Iterative 32x32 multiplier for MUL / MULH / MULHSU / MULHU.
//   32 unsigned shift-add steps build the raw 64-bit product, then two fixed
//   correction steps subtract the sign terms from the high word, so every op
//   completes with the same latency (o_valid in the 35th cycle after accept).
//   Ports:
//     i_clk    : clock, rising edge
//     i_rst_n  : asynchronous active-low reset
//     i_start  : request, accepted only in IDLE without i_kill
//     i_kill   : flush; returns to IDLE on the next edge, no result
//     i_op     : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//     i_rs1    : multiplicand
//     i_rs2    : multiplier
//     o_busy   : high in every non-IDLE state
//     o_valid  : one-cycle strobe in DONE
//     o_result : low word for MUL, high word otherwise; held until next DONE
// ----------------------------------------------------------------------------
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    mul_state_e        r_state;
    mul_state_e        w_next_state;
    logic              w_accept;

    logic [ITER_W-1:0] r_iter;
    mul_op_e           r_op;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic [XLEN-1:0]   r_acc_hi;
    logic [XLEN-1:0]   r_acc_lo;
    logic [XLEN-1:0]   r_result;

    logic [XLEN-1:0]   w_add_a;
    logic [XLEN-1:0]   w_add_b;
    logic              w_add_cin;
    logic              w_add_cout;
    logic [XLEN-1:0]   w_add_sum;

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next state. Kill overrides everything, including a
    // simultaneous start in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        if (i_kill) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_next_state = ST_MUL;
                        w_accept     = 1'b1;
                    end
                end
                ST_MUL: begin
                    if (r_iter == ITER_W'(MUL_ITER - 1)) begin
                        w_next_state = ST_FIX1;
                    end
                end
                ST_FIX1: w_next_state = ST_FIX2;
                ST_FIX2: w_next_state = ST_DONE;
                ST_DONE: w_next_state = ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    assign o_busy   = (r_state != ST_IDLE);
    assign o_valid  = (r_state == ST_DONE);
    assign o_result = r_result;

    // ------------------------------------------------------------------
    // Shared adder operand selection.
    //   MUL  : acc_hi + (acc_lo[0] ? rs1 : 0)
    //   FIX1 : acc_hi - (signed rs1 negative ? rs2 : 0)
    //   FIX2 : acc_hi - (signed rs2 negative ? rs1 : 0)
    // Subtracting zero (~0 + 1) leaves acc_hi unchanged, which keeps the
    // correction steps unconditional.
    // ------------------------------------------------------------------
    always_comb begin
        w_add_a   = r_acc_hi;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        case (r_state)
            ST_MUL: begin
                w_add_b = r_acc_lo[0] ? r_rs1 : '0;
            end
            ST_FIX1: begin
                w_add_b   = ~((rs1_is_signed(r_op) && r_rs1[XLEN-1]) ? r_rs2 : '0);
                w_add_cin = 1'b1;
            end
            ST_FIX2: begin
                w_add_b   = ~((rs2_is_signed(r_op) && r_rs2[XLEN-1]) ? r_rs1 : '0);
                w_add_cin = 1'b1;
            end
            default: begin
                w_add_b   = '0;
                w_add_cin = 1'b0;
            end
        endcase
    end

    adder #(
        .WIDTH (XLEN)
    ) u_adder (
        .op_a (w_add_a),
        .op_b (w_add_b),
        .cin  (w_add_cin),
        .cout (w_add_cout),
        .sum  (w_add_sum)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_iter   <= '0;
            r_op     <= OP_MUL;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_iter   <= '0;
            r_op     <= mul_op_e'(i_op);
            r_rs1    <= i_rs1;
            r_rs2    <= i_rs2;
            r_acc_hi <= '0;
            r_acc_lo <= i_rs2;
        end else if (i_kill) begin
            r_iter   <= '0;
        end else begin
            case (r_state)
                ST_MUL: begin
                    // {cout,sum,acc_lo} >> 1: the consumed multiplier bit falls
                    // off acc_lo while the new product bit enters at its top.
                    r_acc_hi <= {w_add_cout, w_add_sum[XLEN-1:1]};
                    r_acc_lo <= {w_add_sum[0], r_acc_lo[XLEN-1:1]};
                    r_iter   <= r_iter + 1'b1;
                end
                ST_FIX1: begin
                    r_acc_hi <= w_add_sum;
                end
                ST_FIX2: begin
                    // Result register is loaded on the edge into DONE so the
                    // final high word is visible together with o_valid.
                    r_acc_hi <= w_add_sum;
                    r_result <= (r_op == OP_MUL) ? r_acc_lo : w_add_sum;
                end
                default: begin
                    r_iter <= r_iter;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    localparam logic [1:0] T_MUL    = 2'b00;
    localparam logic [1:0] T_MULH   = 2'b01;
    localparam logic [1:0] T_MULHSU = 2'b10;
    localparam logic [1:0] T_MULHU  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    seq_multiplier #(
        .XLEN (32)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_kill   (kill),
        .i_op     (op),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .o_busy   (busy),
        .o_valid  (valid),
        .o_result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and watch 45 cycles. Cycle 1 is the cycle right
    // after the accepting edge; sampling is 1ns after each rising edge.
    task automatic run_op(input logic [1:0] op_v, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int nvalid,
                          output logic busy1, output logic busy36);
        @(negedge clk);
        op = op_v; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        res = '0; lat = 0; nvalid = 0; busy1 = 1'b0; busy36 = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (c == 1)  busy1  = busy;
            if (c == 36) busy36 = busy;
            if (valid) begin
                nvalid++;
                if (lat == 0) begin
                    lat = c;
                    res = result;
                end
            end
        end
    endtask

    task automatic test_reset;
        int waited;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = T_MUL; rs1 = '0; rs2 = '0;
        #2;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
        n_checks++;
        if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 00000000", result); end
        @(negedge clk);
        @(negedge clk);
        // Release and request together: the first rising edge out of reset accepts.
        rst_n = 1'b1; start = 1'b1; op = T_MUL; rs1 = 32'd2; rs2 = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL first_accept_busy got %b exp 1", busy); end
        waited = 0;
        while (busy && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks++;
        if (result !== 32'h4) begin n_fail++; $display("FAIL first_accept_result got %h exp 00000004", result); end
    endtask

    task automatic test_mul_basic;
        logic [31:0] res; int lat, nv; logic b1, b36;
        run_op(T_MUL, 32'd7, 32'd6, res, lat, nv, b1, b36);
        n_checks++;
        if (res !== 32'h0000002A) begin n_fail++; $display("FAIL mul_7x6_result got %h exp 0000002a", res); end
        n_checks++;
        if (lat !== 35) begin n_fail++; $display("FAIL mul_7x6_latency got %0d exp 35", lat); end
        n_checks++;
        if (nv !== 1) begin n_fail++; $display("FAIL mul_7x6_valid_count got %0d exp 1", nv); end
        n_checks++;
        if (b1 !== 1'b1) begin n_fail++; $display("FAIL mul_7x6_busy_cycle1 got %b exp 1", b1); end
        n_checks++;
        if (b36 !== 1'b0) begin n_fail++; $display("FAIL mul_7x6_busy_cycle36 got %b exp 0", b36); end
    endtask

    task automatic test_op_vectors;
        logic [1:0]  v_op  [14];
        logic [31:0] v_a   [14];
        logic [31:0] v_b   [14];
        logic [31:0] v_exp [14];
        logic [31:0] res; int lat, nv; logic b1, b36;
        v_op[0]  = T_MULHU;  v_a[0]  = 32'hFFFFFFFF; v_b[0]  = 32'hFFFFFFFF; v_exp[0]  = 32'hFFFFFFFE;
        v_op[1]  = T_MUL;    v_a[1]  = 32'hFFFFFFFF; v_b[1]  = 32'hFFFFFFFF; v_exp[1]  = 32'h00000001;
        v_op[2]  = T_MULH;   v_a[2]  = 32'h80000000; v_b[2]  = 32'h80000000; v_exp[2]  = 32'h40000000;
        v_op[3]  = T_MULH;   v_a[3]  = 32'hFFFFFFFF; v_b[3]  = 32'h00000002; v_exp[3]  = 32'hFFFFFFFF;
        v_op[4]  = T_MULHSU; v_a[4]  = 32'hFFFFFFFF; v_b[4]  = 32'hFFFFFFFF; v_exp[4]  = 32'hFFFFFFFF;
        // 5 * (2^32-1) = 4*2^32 + (2^32-5): high word 4 when rs2 is unsigned
        v_op[5]  = T_MULHSU; v_a[5]  = 32'd5;        v_b[5]  = 32'hFFFFFFFF; v_exp[5]  = 32'h00000004;
        // 5 * -1 = -5: high word all ones when rs2 is signed
        v_op[6]  = T_MULH;   v_a[6]  = 32'd5;        v_b[6]  = 32'hFFFFFFFF; v_exp[6]  = 32'hFFFFFFFF;
        v_op[7]  = T_MULHU;  v_a[7]  = 32'd5;        v_b[7]  = 32'hFFFFFFFF; v_exp[7]  = 32'h00000004;
        // 2^30 * 2^30 = 2^60
        v_op[8]  = T_MULH;   v_a[8]  = 32'h40000000; v_b[8]  = 32'h40000000; v_exp[8]  = 32'h10000000;
        // -2^31 * 2 = -2^32: high word all ones
        v_op[9]  = T_MULHSU; v_a[9]  = 32'h80000000; v_b[9]  = 32'h00000002; v_exp[9]  = 32'hFFFFFFFF;
        v_op[10] = T_MULHU;  v_a[10] = 32'h80000000; v_b[10] = 32'h00000002; v_exp[10] = 32'h00000001;
        v_op[11] = T_MUL;    v_a[11] = 32'h12345678; v_b[11] = 32'h00000010; v_exp[11] = 32'h23456780;
        v_op[12] = T_MUL;    v_a[12] = 32'hFFFFFFFF; v_b[12] = 32'h00000002; v_exp[12] = 32'hFFFFFFFE;
        // 0x10000 * 0x10000 = 2^32: low 0, high 1
        v_op[13] = T_MULHU;  v_a[13] = 32'h00010000; v_b[13] = 32'h00010000; v_exp[13] = 32'h00000001;
        for (int i = 0; i < 14; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], res, lat, nv, b1, b36);
            n_checks++;
            if (res !== v_exp[i]) begin
                n_fail++;
                $display("FAIL vec%0d_result op=%b a=%h b=%h got %h exp %h", i, v_op[i], v_a[i], v_b[i], res, v_exp[i]);
            end
            n_checks++;
            if (lat !== 35) begin n_fail++; $display("FAIL vec%0d_latency got %0d exp 35", i, lat); end
            n_checks++;
            if (nv !== 1) begin n_fail++; $display("FAIL vec%0d_valid_count got %0d exp 1", i, nv); end
        end
    endtask

    task automatic test_ignored_start;
        int nv, lat; logic [31:0] res; logic b36;
        @(negedge clk);
        op = T_MUL; rs1 = 32'h00010001; rs2 = 32'h00000003; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nv = 0; lat = 0; res = '0; b36 = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (valid) begin
                nv++;
                if (lat == 0) begin lat = c; res = result; end
            end
            if (c == 36) b36 = busy;
            if (c == 5 || c == 34) begin
                op = T_MULHU; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; start = 1'b1;
            end else if (c == 6 || c == 36) begin
                start = 1'b0;
            end
        end
        n_checks++;
        if (res !== 32'h00030003) begin n_fail++; $display("FAIL busy_start_result got %h exp 00030003", res); end
        n_checks++;
        if (lat !== 35) begin n_fail++; $display("FAIL busy_start_latency got %0d exp 35", lat); end
        n_checks++;
        if (nv !== 1) begin n_fail++; $display("FAIL busy_start_valid_count got %0d exp 1", nv); end
        n_checks++;
        if (b36 !== 1'b0) begin n_fail++; $display("FAIL done_start_busy36 got %b exp 0", b36); end
        n_checks++;
        if (result !== 32'h00030003) begin n_fail++; $display("FAIL result_hold got %h exp 00030003", result); end
    endtask

    task automatic test_kill;
        int nv, lat; logic [31:0] res; logic b1, b36;
        run_op(T_MUL, 32'h100, 32'h100, res, lat, nv, b1, b36);
        n_checks++;
        if (res !== 32'h00010000) begin n_fail++; $display("FAIL kill_baseline got %h exp 00010000", res); end
        @(negedge clk);
        op = T_MULHU; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nv = 0;
        for (int c = 1; c <= 50; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (valid) nv++;
            if (c == 10) kill = 1'b1;
            if (c == 11) begin
                kill = 1'b0;
                n_checks++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got %b exp 0", busy); end
            end
        end
        n_checks++;
        if (nv !== 0) begin n_fail++; $display("FAIL kill_valid_count got %0d exp 0", nv); end
        n_checks++;
        if (result !== 32'h00010000) begin n_fail++; $display("FAIL kill_result_kept got %h exp 00010000", result); end
        // Kill wins over a simultaneous start.
        @(negedge clk);
        op = T_MUL; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_start_priority busy got %b exp 0", busy); end
        run_op(T_MUL, 32'd3, 32'd5, res, lat, nv, b1, b36);
        n_checks++;
        if (res !== 32'h0000000F) begin n_fail++; $display("FAIL post_kill_mul got %h exp 0000000f", res); end
        n_checks++;
        if (lat !== 35) begin n_fail++; $display("FAIL post_kill_latency got %0d exp 35", lat); end
    endtask

    task automatic test_reset_mid;
        int nv, lat; logic [31:0] res; logic b1, b36;
        @(negedge clk);
        op = T_MULH; rs1 = 32'h80000000; rs2 = 32'h80000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 2; c <= 20; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b exp 0", busy); end
        n_checks++;
        if (result !== 32'h0) begin n_fail++; $display("FAIL midreset_result got %h exp 00000000", result); end
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (valid) nv++;
        end
        n_checks++;
        if (nv !== 0) begin n_fail++; $display("FAIL midreset_valid_count got %0d exp 0", nv); end
        run_op(T_MUL, 32'd3, 32'd5, res, lat, nv, b1, b36);
        n_checks++;
        if (res !== 32'h0000000F) begin n_fail++; $display("FAIL post_reset_mul got %h exp 0000000f", res); end
        n_checks++;
        if (nv !== 1) begin n_fail++; $display("FAIL post_reset_valid_count got %0d exp 1", nv); end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_op_vectors();
        test_ignored_start();
        test_kill();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and result width; only 32 is supported.
REQ-002 SHALL have port i_clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_start  input  1  request; accepted only when o_busy=0.
REQ-005 SHALL have port i_kill  input  1  pipeline flush; aborts any operation in flight.
REQ-006 SHALL have port i_op  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 SHALL have port i_rs1  input  32  multiplicand; signed for MULH and MULHSU.
REQ-008 SHALL have port i_rs2  input  32  multiplier; signed for MULH only.
REQ-009 SHALL have port o_busy  output  1  high from the cycle after acceptance until o_valid has completed.
REQ-010 SHALL have port o_valid  output  1  single-cycle result strobe.
REQ-011 SHALL have port o_result  output  32  result: low product word for MUL, high product word otherwise.

Function
REQ-012 SHALL accept a request on a rising edge where i_start=1, o_busy=0 and i_kill=0, latching i_op, i_rs1 and i_rs2.
REQ-013 SHALL use the FSM states IDLE -> MUL -> FIX1 -> FIX2 -> DONE -> IDLE.
REQ-014 SHALL stay in MUL for exactly 32 cycles, tracked by a 5-bit iteration counter that starts at 0 and leaves MUL at 31.
REQ-015 SHALL perform one shift-add step per MUL cycle on acc_hi (32 bit) and acc_lo (32 bit, initialised to rs2), with acc_hi initialised to 0.
REQ-016 Each MUL step SHALL compute {cout,sum} = acc_hi + (acc_lo[0] ? rs1 : 0), then load acc_hi/acc_lo with {cout,sum,acc_lo} shifted right by one.
REQ-017 After MUL, {acc_hi,acc_lo} SHALL hold the unsigned 64-bit product of the latched operands.
REQ-018 In FIX1, acc_hi SHALL become acc_hi - ((rs1 signed-treated and rs1[31]) ? rs2 : 0).
REQ-019 In FIX2, acc_hi SHALL become acc_hi - ((rs2 signed-treated and rs2[31]) ? rs1 : 0).
REQ-020 Each subtraction in FIX1/FIX2 SHALL be an addition of the bitwise-inverted operand with cin=1.
REQ-021 FIX1 and FIX2 SHALL always execute, even for MUL/MULHU, with a zero operand where no correction applies, so latency is fixed.
REQ-022 All additions SHALL use a single shared 32-bit adder instance, with operand muxes selected by state.
REQ-023 In DONE, o_valid SHALL be 1 for exactly one cycle, in the 35th cycle after the accepting edge, for every i_op.
REQ-024 In DONE, o_result SHALL equal acc_lo for MUL and acc_hi otherwise.
REQ-025 o_result SHALL be held until the next DONE.
REQ-026 i_start while o_busy=1 SHALL be ignored, with no queuing.
REQ-027 i_start in the DONE cycle SHALL be ignored.
REQ-028 i_kill=1 in any state SHALL force IDLE on the next edge, suppress o_valid and leave o_result unchanged.
REQ-029 i_kill SHALL take priority over a simultaneous i_start.

Reset
REQ-030 On i_rst_n=0, the block SHALL immediately force state=IDLE, counter=0, acc_hi=0, acc_lo=0, o_busy=0, o_valid=0 and o_result=0, independent of i_clk.
REQ-031 Reset mid-operation SHALL discard the operation, with no o_valid after release.
REQ-032 The first request SHALL be accepted on the first rising edge with i_rst_n=1.

Structure
REQ-033 A shared package SHALL hold the mul_op_e enum (MUL, MULH, MULHSU, MULHU), the mul_state_e enum (IDLE, MUL, FIX1, FIX2, DONE) and the constant MUL_ITER=32.
REQ-034 The existing 32-bit ripple adder module, adder (ports op_a, op_b, cin, cout, sum), SHALL be instantiated as the sole sub-module.
REQ-035 No behavioural multiply operator SHALL be used.

Verification
REQ-036 MUL, rs1=7, rs2=6 -> o_valid in cycle 35 after accept, o_result=0x0000002A.
REQ-037 MULHU, rs1=rs2=0xFFFFFFFF -> o_result=0xFFFFFFFE; MUL with the same operands -> o_result=0x00000001.
REQ-038 MULH, rs1=rs2=0x80000000 -> o_result=0x40000000; MULH, rs1=0xFFFFFFFF, rs2=0x00000002 -> o_result=0xFFFFFFFF.
REQ-039 MULHSU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> o_result=0xFFFFFFFF.
REQ-040 i_start pulsed with new operands at cycles 5 and 34 of a busy operation -> ignored; the first result is unchanged and exactly one o_valid occurs.
REQ-041 i_kill at cycle 10, or i_rst_n low at cycle 20 -> o_busy=0 next cycle, no o_valid; a following MUL 3*5 -> o_result=0x0000000F.
